transpose_stream_sched: RTL and testbench

- Sequencer for the 32x32 streaming transpose core in the AFU datapath.
- Per context it:
  - pops 512-bit lines from the input FIFO and drives the core's clk_en/start;
  - flushes the core pipeline after the last input line;
  - writes core outputs into the output FIFO only when a credit is guaranteed, so the output FIFO never overflows;
  - reports done and error status to the AFU control logic.

---
 rtl/transpose_stream_sched_if.sv | 43 ++++
 rtl/transpose_stream_sched.sv | 170 +++++++++++++++++
 tb/tb_transpose_stream_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_stream_sched_if.sv
// transpose_stream_sched_if
//   Groups the control, FIFO handshake, core handshake and status signals of
//   the transpose stream scheduler.
//   master : AFU control / FIFOs / core side (drives requests and flags)
//   slave  : scheduler side
//   Signals:
//     ctx_start, ctx_length        context request
//     in_empty, in_re              input FIFO handshake
//     core_clk_en, core_start,
//     core_valid_out               transpose core handshake
//     out_we, out_re               output FIFO write / consumer pop
//     busy, done, err,
//     lines_in, lines_out          status
interface transpose_stream_sched_if #(
  parameter int CNT_W = 32
) ();
  logic             ctx_start;
  logic [CNT_W-1:0] ctx_length;
  logic             in_empty;
  logic             in_re;
  logic             core_clk_en;
  logic             core_start;
  logic             core_valid_out;
  logic             out_we;
  logic             out_re;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] lines_in;
  logic [CNT_W-1:0] lines_out;

  modport master (
    output ctx_start, ctx_length, in_empty, core_valid_out, out_re,
    input  in_re, core_clk_en, core_start, out_we, busy, done, err,
           lines_in, lines_out
  );

  modport slave (
    input  ctx_start, ctx_length, in_empty, core_valid_out, out_re,
    output in_re, core_clk_en, core_start, out_we, busy, done, err,
           lines_in, lines_out
  );
endinterface

// File: rtl/transpose_stream_sched.sv
// transpose_stream_sched
//   Sequencer for the 32x32 streaming transpose core. Pops input lines,
//   advances the core, flushes its pipeline after the last line and writes
//   core outputs into the output FIFO only when a credit is guaranteed.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     bus    transpose_stream_sched_if.slave (see interface header)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, waiting for ctx_start
//   RUN    | popping input lines, one core step per pop
//   FLUSH  | all lines popped, stepping the core until all outputs written
//   DONE   | context finished (err tells bad length / flush timeout)
module transpose_stream_sched #(
  parameter int LINES_PER_BLOCK = 32,
  parameter int OUT_DEPTH       = 8,
  parameter int CNT_W           = 32,
  parameter int MAX_FLUSH       = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  transpose_stream_sched_if.slave   bus
);

  localparam int CRED_W  = $clog2(OUT_DEPTH + 1);
  localparam int FLUSH_W = $clog2(MAX_FLUSH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   lines_in_q;
  logic [CNT_W-1:0]   lines_out_q;
  logic [CRED_W-1:0]  credits_q;
  logic [FLUSH_W-1:0] flush_cnt_q;
  logic               step_q;
  logic               start_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               can_issue;
  logic               in_re;
  logic               out_we;
  logic               cred_inc;
  logic               len_bad;
  logic               flush_step;
  logic [CRED_W-1:0]  credits_d;
  logic [CNT_W-1:0]   lines_out_d;

  // A step already in flight may write this cycle; a new step may write next
  // cycle. Require a credit for each so the output FIFO cannot overflow.
  assign can_issue = credits_q >= (step_q ? CRED_W'(2) : CRED_W'(1));

  // Gated by reset so an abort never pops or writes in the reset cycle.
  assign in_re  = (state_q == S_RUN) & ~bus.in_empty & can_issue &
                  (lines_in_q != len_q) & ~reset;
  assign out_we = bus.core_valid_out & step_q & ~reset;

  // A pop with the FIFO already empty (all credits home) is ignored.
  assign cred_inc = bus.out_re & (credits_q != CRED_W'(OUT_DEPTH));

  always_comb begin
    credits_d = credits_q;
    if (cred_inc && !out_we) begin
      credits_d = credits_q + CRED_W'(1);
    end else if (!cred_inc && out_we) begin
      credits_d = credits_q - CRED_W'(1);
    end
  end

  assign lines_out_d = (out_we && (lines_out_q != CNT_MAX)) ?
                       lines_out_q + CNT_W'(1) : lines_out_q;

  assign len_bad = (bus.ctx_length == '0) ||
                   ((bus.ctx_length % CNT_W'(LINES_PER_BLOCK)) != '0);

  assign flush_step = can_issue & (lines_out_d != len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      lines_in_q  <= '0;
      lines_out_q <= '0;
      credits_q   <= CRED_W'(OUT_DEPTH);
      flush_cnt_q <= '0;
      step_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      lines_out_q <= lines_out_d;
      step_q      <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.ctx_start) begin
            len_q       <= bus.ctx_length;
            lines_in_q  <= '0;
            lines_out_q <= '0;
            flush_cnt_q <= '0;
            if (len_bad) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          step_q  <= in_re;
          start_q <= in_re;
          if (in_re) begin
            if (lines_in_q != CNT_MAX) begin
              lines_in_q <= lines_in_q + CNT_W'(1);
            end
            if ((lines_in_q + CNT_W'(1)) == len_q) begin
              state_q     <= S_FLUSH;
              flush_cnt_q <= '0;
            end
          end
        end
        S_FLUSH: begin
          if ((lines_out_q == len_q) && !step_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (flush_cnt_q == FLUSH_W'(MAX_FLUSH)) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            step_q <= flush_step;
            if (flush_step) begin
              flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_re       = in_re;
  assign bus.core_clk_en = step_q;
  assign bus.core_start  = start_q;
  assign bus.out_we      = out_we;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.lines_in    = lines_in_q;
  assign bus.lines_out   = lines_out_q;

endmodule

// File: tb/tb_transpose_stream_sched.sv
// tb_transpose_stream_sched
//   Self-checking bench for transpose_stream_sched. Models the input FIFO,
//   a transpose core (step-advanced pipeline carrying line tags) and the
//   output FIFO with a consumer, plus a behavioural scheduler model compared
//   against the DUT every cycle.
module tb_transpose_stream_sched;
  localparam int CNT_W     = 32;
  localparam int OUT_DEPTH = 8;
  localparam int MAX_FLUSH = 128;
  localparam int LPB       = 32;

  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  transpose_stream_sched_if #(.CNT_W(CNT_W)) bus ();

  transpose_stream_sched #(
    .LINES_PER_BLOCK(LPB), .OUT_DEPTH(OUT_DEPTH),
    .CNT_W(CNT_W), .MAX_FLUSH(MAX_FLUSH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus for the next cycle
  bit stim_reset = 1'b1;
  bit stim_start = 1'b0;
  int stim_len   = 0;
  bit force_re   = 1'b0;

  // environment
  int in_avail = 0;
  int feed_mode = 0;      // 0 prefilled, 1 every 3rd cycle, 2 random
  int feed_budget = 0;
  bit cons_en = 1'b1;
  int cons_pct = 100;
  int out_occ = 0;
  bit pipe_v [256];
  int pipe_tag [256];
  int core_lat = 33;
  int next_in_tag = 0;
  int exp_out_tag = 0;
  int pending_tag = 0;
  int cnt_in_re = 0, cnt_we = 0, cnt_clk_en = 0;

  // behavioural model of the scheduler
  bit model_valid = 1'b0;
  int m_state = M_IDLE;
  int m_len = 0, m_cred = OUT_DEPTH, m_flush = 0, m_lin = 0, m_lout = 0;
  bit m_step = 1'b0, m_start = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) begin
      pipe_v[i]   = 1'b0;
      pipe_tag[i] = 0;
    end
    out_occ     = 0;
    in_avail    = 0;
    feed_budget = 0;
    exp_out_tag = next_in_tag;
  endtask

  task automatic cycle();
    bit can, e_ire, e_we, step_n, ire, we, ore, cen, cst;
    int lout_n;
    @(negedge clk);
    reset              = stim_reset;
    bus.ctx_start      = stim_start;
    bus.ctx_length     = CNT_W'(stim_len);
    bus.in_empty       = (in_avail == 0);
    bus.core_valid_out = pipe_v[core_lat-1];
    bus.out_re         = force_re ||
                         (cons_en && out_occ > 0 && $urandom_range(0, 99) < cons_pct);
    #1;
    can   = (m_cred >= 1 + int'(m_step));
    e_ire = !stim_reset && m_state == M_RUN && !bus.in_empty && can && m_lin != m_len;
    e_we  = !stim_reset && bus.core_valid_out && m_step;
    if (model_valid) begin
      chk("in_re", bus.in_re, e_ire);
      chk("out_we", bus.out_we, e_we);
      chk("core_clk_en", bus.core_clk_en, m_step);
      chk("core_start", bus.core_start, m_start);
      chk("busy", bus.busy, (m_state == M_RUN || m_state == M_FLUSH));
      chk("done", bus.done, (m_state == M_DONE));
      chk("err", bus.err, m_err);
      chk("lines_in", bus.lines_in, m_lin);
      chk("lines_out", bus.lines_out, m_lout);
    end
    ire = bus.in_re; we = bus.out_we; ore = bus.out_re;
    cen = bus.core_clk_en; cst = bus.core_start;
    if (stim_reset) begin
      clear_env();
    end else begin
      if (we) begin
        chk("out_tag", pipe_tag[core_lat-1], exp_out_tag);
        exp_out_tag++;
        out_occ++;
        chk("out_fifo_no_overflow", (out_occ <= OUT_DEPTH), 1);
        cnt_we++;
      end
      if (ore && out_occ > 0) out_occ--;
      if (cen) begin
        cnt_clk_en++;
        for (int i = core_lat - 1; i > 0; i--) begin
          pipe_v[i]   = pipe_v[i-1];
          pipe_tag[i] = pipe_tag[i-1];
        end
        pipe_v[0]   = cst;
        pipe_tag[0] = pending_tag;
      end
      if (ire) begin
        if (in_avail > 0) in_avail--;
        pending_tag = next_in_tag;
        next_in_tag++;
        cnt_in_re++;
      end
      if (feed_budget > 0 &&
          ((feed_mode == 1 && cyc % 3 == 0) ||
           (feed_mode == 2 && $urandom_range(0, 1) == 1))) begin
        in_avail++;
        feed_budget--;
      end
    end
    // scheduler model advance
    if (stim_reset) begin
      model_valid = 1'b1;
      m_state = M_IDLE; m_len = 0; m_cred = OUT_DEPTH; m_flush = 0;
      m_lin = 0; m_lout = 0; m_step = 1'b0; m_start = 1'b0; m_err = 1'b0;
    end else begin
      lout_n = m_lout + int'(e_we);
      step_n = 1'b0;
      m_cred = m_cred + ((bus.out_re && m_cred != OUT_DEPTH) ? 1 : 0) - int'(e_we);
      case (m_state)
        M_IDLE, M_DONE: begin
          if (stim_start) begin
            m_lin = 0; lout_n = 0; m_len = stim_len;
            if (stim_len == 0 || stim_len % LPB != 0) begin
              m_err = 1'b1; m_state = M_DONE;
            end else begin
              m_err = 1'b0; m_state = M_RUN;
            end
          end
        end
        M_RUN: begin
          step_n = e_ire;
          m_lin  = m_lin + int'(e_ire);
          if (e_ire && m_lin == m_len) begin
            m_state = M_FLUSH; m_flush = 0;
          end
        end
        default: begin
          if (m_lout == m_len && !m_step) begin
            m_state = M_DONE;
          end else if (m_flush == MAX_FLUSH) begin
            m_err = 1'b1; m_state = M_DONE;
          end else begin
            step_n  = can && (lout_n != m_len);
            m_flush = m_flush + int'(step_n);
          end
        end
      endcase
      m_start = e_ire;
      m_step  = step_n;
      m_lout  = lout_n;
    end
    cyc++;
    stim_start = 1'b0;
    stim_reset = 1'b0;
  endtask

  task automatic start_ctx(input int len);
    stim_start = 1'b1;
    stim_len   = len;
    cycle();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (bus.done !== 1'b1 && n < budget);
    chk({name, "_reached_done"}, bus.done, 1);
  endtask

  task automatic drain();
    int n = 0;
    cons_en = 1'b1; cons_pct = 100;
    while (out_occ > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_out_fifo", out_occ, 0);
  endtask

  task automatic clear_counts();
    cnt_in_re = 0; cnt_we = 0; cnt_clk_en = 0;
  endtask

  initial begin
    int n;
    int len;
    bus.ctx_start = 1'b0; bus.ctx_length = '0; bus.in_empty = 1'b1;
    bus.core_valid_out = 1'b0; bus.out_re = 1'b0;
    clear_env();

    stim_reset = 1'b1; cycle();
    stim_reset = 1'b1; cycle();
    cycle();
    chk("reset_in_re", bus.in_re, 0);
    chk("reset_out_we", bus.out_we, 0);
    chk("reset_clk_en", bus.core_clk_en, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_lines_in", bus.lines_in, 0);

    // basic context, with an ignored ctx_start while busy
    clear_counts(); feed_mode = 0; in_avail = 32; cons_en = 1'b1; cons_pct = 100;
    core_lat = 33;
    start_ctx(32);
    repeat (5) cycle();
    stim_start = 1'b1; stim_len = 0;
    wait_done("basic", 600);
    chk("basic_in_re_count", cnt_in_re, 32);
    chk("basic_out_we_count", cnt_we, 32);
    chk("basic_lines_in", bus.lines_in, 32);
    chk("basic_lines_out", bus.lines_out, 32);
    chk("basic_err", bus.err, 0);
    drain();

    // pops with all credits home must not add credits
    force_re = 1'b1; repeat (3) cycle(); force_re = 1'b0;

    // backpressure
    clear_counts(); in_avail = 64; cons_en = 1'b0;
    start_ctx(64);
    repeat (300) cycle();
    chk("bp_out_we_stalls_at_depth", cnt_we, OUT_DEPTH);
    chk("bp_still_busy", bus.busy, 1);
    cons_en = 1'b1; cons_pct = 50;
    wait_done("bp", 3000);
    chk("bp_out_we_count", cnt_we, 64);
    chk("bp_in_re_count", cnt_in_re, 64);
    chk("bp_lines_out", bus.lines_out, 64);
    drain();

    // starved input
    clear_counts(); feed_mode = 1; feed_budget = 32; in_avail = 0;
    start_ctx(32);
    wait_done("starve", 1000);
    chk("starve_in_re_count", cnt_in_re, 32);
    chk("starve_out_we_count", cnt_we, 32);
    chk("starve_err", bus.err, 0);
    drain();

    // bad lengths then a good one
    clear_counts(); feed_mode = 0;
    start_ctx(0); cycle();
    chk("len0_done", bus.done, 1);
    chk("len0_err", bus.err, 1);
    start_ctx(33); cycle();
    chk("len33_done", bus.done, 1);
    chk("len33_err", bus.err, 1);
    chk("bad_len_no_pops", cnt_in_re, 0);
    in_avail = 32;
    start_ctx(32); cycle();
    chk("good_after_bad_err_clear", bus.err, 0);
    wait_done("good_after_bad", 600);
    chk("good_after_bad_lines_out", bus.lines_out, 32);
    chk("good_after_bad_err", bus.err, 0);
    drain();

    // randomized contexts
    for (int k = 0; k < 6; k++) begin
      clear_counts();
      len = LPB * int'($urandom_range(1, 3));
      core_lat = int'($urandom_range(1, 40));
      feed_mode = 2; feed_budget = len; in_avail = 0;
      cons_en = 1'b1; cons_pct = int'($urandom_range(20, 90));
      start_ctx(len);
      wait_done("random", 5000);
      chk("random_out_we_count", cnt_we, len);
      chk("random_err", bus.err, 0);
      drain();
    end

    // flush timeout: core never produces output
    clear_counts(); feed_mode = 0; in_avail = 32; core_lat = 200;
    start_ctx(32);
    wait_done("timeout", 1000);
    chk("timeout_err", bus.err, 1);
    chk("timeout_clk_en_count", cnt_clk_en, 32 + MAX_FLUSH);
    chk("timeout_out_we_count", cnt_we, 0);
    stim_reset = 1'b1; cycle();
    core_lat = 33;

    // reset mid-FLUSH after 10 outputs
    clear_counts(); in_avail = 32; cons_en = 1'b1; cons_pct = 100;
    start_ctx(32);
    n = 0;
    while (bus.lines_out != 10 && n < 500) begin
      cycle();
      n++;
    end
    chk("midflush_reached_10", bus.lines_out, 10);
    chk("midflush_in_flush", bus.lines_in, 32);
    stim_reset = 1'b1; cycle();
    cycle();
    chk("post_reset_in_re", bus.in_re, 0);
    chk("post_reset_out_we", bus.out_we, 0);
    chk("post_reset_clk_en", bus.core_clk_en, 0);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_lines_out", bus.lines_out, 0);
    clear_counts(); in_avail = 32; cons_en = 1'b0;
    start_ctx(32);
    repeat (120) cycle();
    chk("post_reset_credits_full", cnt_we, OUT_DEPTH);
    cons_en = 1'b1;
    wait_done("post_reset_ctx", 1000);
    chk("post_reset_ctx_out", cnt_we, 32);
    chk("post_reset_ctx_err", bus.err, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
